// File: rtl/memory_access.sv
// memory_access: Y86-64 M pipeline stage; holds the M register and runs one req/ack data-memory access per instruction.
// Define MEM_ALIGN_CHECK_EN to suppress misaligned accesses and report SADR instead.
module memory_access (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        memory_stall_i,
  input  logic        memory_bubble_i,
  input  logic [3:0]  icode_i,
  input  logic [2:0]  stat_i,
  input  logic        e_cnd_i,
  input  logic [63:0] valE_i,
  input  logic [63:0] valA_i,
  input  logic [3:0]  dstE_i,
  input  logic [3:0]  dstM_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [63:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [63:0] dmem_rdata_i,
  input  logic        dmem_err_i,
  output logic        mem_busy_o,
  output logic [2:0]  m_stat_o,
  output logic [3:0]  icode_o,
  output logic [63:0] valE_o,
  output logic [63:0] valM_o,
  output logic [3:0]  dstE_o,
  output logic [3:0]  dstM_o,
  output logic [2:0]  stat_o
);

  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [2:0] SAOK    = 3'd1;
  localparam logic [2:0] SADR    = 3'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  state_t      state;
  logic [3:0]  m_icode;
  logic [2:0]  m_stat;
  logic        m_cnd_unused;
  logic [63:0] m_vale;
  logic [63:0] m_vala;
  logic [3:0]  m_dste;
  logic [3:0]  m_dstm;
  logic [63:0] valm_q;
  logic        err_q;

  logic        is_read;
  logic        is_write;
  logic        misaligned;
  logic        access;
  logic        busy;
  logic        advance;
  logic [63:0] addr;

  assign is_read  = (m_icode == IMRMOVQ) || (m_icode == IPOPQ) || (m_icode == IRET);
  assign is_write = (m_icode == IRMMOVQ) || (m_icode == ICALL) || (m_icode == IPUSHQ);
  assign addr     = ((m_icode == IPOPQ) || (m_icode == IRET)) ? m_vala : m_vale;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (is_read || is_write) && (addr[2:0] != 3'b000);
`else
  assign misaligned = 1'b0;
`endif

  assign access  = (is_read || is_write) && (m_stat == SAOK) && !misaligned;
  // The M register only moves while no access is outstanding, so request fields stay stable in WAIT.
  assign busy    = (state == WAIT) || ((state == IDLE) && access);
  assign advance = !busy;

  // cnd is carried with the instruction but nothing past M consumes it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_icode      <= INOP;
      m_stat       <= SAOK;
      m_cnd_unused <= 1'b0;
      m_vale       <= '0;
      m_vala       <= '0;
      m_dste       <= RNONE;
      m_dstm       <= RNONE;
    end else if (advance && memory_bubble_i) begin
      m_icode      <= INOP;
      m_stat       <= SAOK;
      m_cnd_unused <= 1'b0;
      m_vale       <= '0;
      m_vala       <= '0;
      m_dste       <= RNONE;
      m_dstm       <= RNONE;
    end else if (advance && !memory_stall_i) begin
      m_icode      <= icode_i;
      m_stat       <= stat_i;
      m_cnd_unused <= e_cnd_i;
      m_vale       <= valE_i;
      m_vala       <= valA_i;
      m_dste       <= dstE_i;
      m_dstm       <= dstM_i;
    end
  end

  // DONE persists while a stall holds the finished instruction, so it is never issued twice.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      valm_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, WAIT: begin
          if (busy) begin
            if (dmem_ack_i) begin
              state  <= DONE;
              valm_q <= is_read ? dmem_rdata_i : 64'd0;
              err_q  <= dmem_err_i;
            end else begin
              state <= WAIT;
            end
          end
        end
        DONE: begin
          if (memory_bubble_i || !memory_stall_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    m_stat_o = m_stat;
    if ((state == DONE) && err_q) m_stat_o = SADR;
    else if (misaligned && (m_stat == SAOK)) m_stat_o = SADR;
  end

  assign dmem_req_o   = busy;
  assign dmem_we_o    = busy && is_write;
  assign dmem_addr_o  = addr;
  assign dmem_wdata_o = m_vala;
  assign mem_busy_o   = busy;

  assign icode_o = m_icode;
  assign valE_o  = m_vale;
  assign valM_o  = (state == DONE) ? valm_q : 64'd0;
  assign dstE_o  = m_dste;
  assign dstM_o  = m_dstm;
  assign stat_o  = m_stat_o;

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: scoreboard bench for memory_access; expected accesses are queued at drive time.
// Build with MEM_ALIGN_CHECK_EN defined to exercise the alignment-check variant.
module tb_memory_access;

  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [2:0] SAOK    = 3'd1;
  localparam logic [2:0] SADR    = 3'd3;
  localparam logic [2:0] SINS    = 3'd4;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [3:0]  icode;
    logic [3:0]  dste;
    logic [3:0]  dstm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memory_stall, memory_bubble;
  logic [3:0]  icode_in;
  logic [2:0]  stat_in;
  logic        e_cnd;
  logic [63:0] vale_in, vala_in;
  logic [3:0]  dste_in, dstm_in;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic        dmem_ack, dmem_err;
  logic [63:0] dmem_rdata;
  logic        mem_busy;
  logic [2:0]  m_stat, stat_out;
  logic [3:0]  icode_out, dste_out, dstm_out;
  logic [63:0] vale_out, valm_out;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  memory_access dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .memory_stall_i(memory_stall), .memory_bubble_i(memory_bubble),
    .icode_i(icode_in), .stat_i(stat_in), .e_cnd_i(e_cnd),
    .valE_i(vale_in), .valA_i(vala_in), .dstE_i(dste_in), .dstM_i(dstm_in),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata),
    .dmem_ack_i(dmem_ack), .dmem_rdata_i(dmem_rdata), .dmem_err_i(dmem_err),
    .mem_busy_o(mem_busy), .m_stat_o(m_stat),
    .icode_o(icode_out), .valE_o(vale_out), .valM_o(valm_out),
    .dstE_o(dste_out), .dstM_o(dstm_out), .stat_o(stat_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, actual, expected, $time);
    end
  endtask

  // Drives the execute-side inputs and queues the access the instruction should make.
  task automatic applyStimulus(input logic [3:0] icode, input logic [2:0] stat,
                               input logic [63:0] vale, input logic [63:0] vala,
                               input logic [3:0] dste, input logic [3:0] dstm);
    logic rd, wr, acc;
    exp_t e;
    icode_in = icode; stat_in = stat; e_cnd = 1'b0;
    vale_in = vale; vala_in = vala; dste_in = dste; dstm_in = dstm;
    rd = (icode == IMRMOVQ) || (icode == IPOPQ) || (icode == IRET);
    wr = (icode == IRMMOVQ) || (icode == ICALL) || (icode == IPUSHQ);
    e.addr  = ((icode == IPOPQ) || (icode == IRET)) ? vala : vale;
    e.we    = wr;
    e.wdata = vala;
    e.icode = icode;
    e.dste  = dste;
    e.dstm  = dstm;
    acc = (rd || wr) && (stat == SAOK);
`ifdef MEM_ALIGN_CHECK_EN
    if (e.addr[2:0] != 3'b000) acc = 1'b0;
`endif
    if (acc) exp_q.push_back(e);
  endtask

  // Lets the previously driven instruction enter M, answers after 'delay' wait cycles, checks DONE.
  task automatic runAccess(input int delay, input logic [63:0] rdata, input logic err, input logic disturb);
    exp_t e;
    @(posedge clk); #1;
    applyStimulus(INOP, SAOK, 64'd0, 64'd0, RNONE, RNONE);
    memory_stall = disturb; memory_bubble = disturb;
    checkOutput("sb_pending", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    for (int k = 0; k <= delay; k++) begin
      dmem_ack = (k == delay); dmem_rdata = rdata; dmem_err = err;
      @(negedge clk);
      checkOutput("req", 64'(dmem_req), 64'd1);
      checkOutput("busy", 64'(mem_busy), 64'd1);
      checkOutput("addr", dmem_addr, e.addr);
      checkOutput("we", 64'(dmem_we), 64'(e.we));
      checkOutput("wdata", dmem_wdata, e.wdata);
      checkOutput("icode_hold", 64'(icode_out), 64'(e.icode));
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0; dmem_err = 1'b0; dmem_rdata = ~rdata;
    memory_stall = 1'b0; memory_bubble = 1'b0;
    @(negedge clk);
    checkOutput("done_req", 64'(dmem_req), 64'd0);
    checkOutput("done_busy", 64'(mem_busy), 64'd0);
    checkOutput("valM", valm_out, e.we ? 64'd0 : rdata);
    checkOutput("stat", 64'(stat_out), err ? 64'(SADR) : 64'(SAOK));
    checkOutput("m_stat", 64'(m_stat), err ? 64'(SADR) : 64'(SAOK));
    checkOutput("dstE", 64'(dste_out), 64'(e.dste));
    checkOutput("dstM", 64'(dstm_out), 64'(e.dstm));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] ra, rd;
    rst_n = 1'b0;
    memory_stall = 1'b0; memory_bubble = 1'b0;
    icode_in = IMRMOVQ; stat_in = SAOK; e_cnd = 1'b1;
    vale_in = 64'h100; vala_in = 64'h8; dste_in = 4'h2; dstm_in = 4'h3;
    dmem_ack = 1'b0; dmem_err = 1'b0; dmem_rdata = 64'h0;
    #12;
    checkOutput("rst_icode", 64'(icode_out), 64'(INOP));
    checkOutput("rst_stat", 64'(stat_out), 64'(SAOK));
    checkOutput("rst_m_stat", 64'(m_stat), 64'(SAOK));
    checkOutput("rst_dstE", 64'(dste_out), 64'(RNONE));
    checkOutput("rst_dstM", 64'(dstm_out), 64'(RNONE));
    checkOutput("rst_req", 64'(dmem_req), 64'd0);
    checkOutput("rst_busy", 64'(mem_busy), 64'd0);
    checkOutput("rst_valE", vale_out, 64'd0);
    checkOutput("rst_valM", valm_out, 64'd0);
    applyStimulus(INOP, SAOK, 64'd0, 64'd0, RNONE, RNONE);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] mrmovq, ack in the request cycle");
    applyStimulus(IMRMOVQ, SAOK, 64'h100, 64'h0, RNONE, 4'h2);
    runAccess(0, 64'hDEAD, 1'b0, 1'b0);

    $display("[TB] pushq, three wait cycles, stall and bubble while busy");
    applyStimulus(IPUSHQ, SAOK, 64'h1F8, 64'h55, 4'h4, RNONE);
    runAccess(3, 64'h1234, 1'b0, 1'b1);

    $display("[TB] popq with error response");
    applyStimulus(IPOPQ, SAOK, 64'h208, 64'h200, 4'h4, 4'h6);
    runAccess(1, 64'h77, 1'b1, 1'b0);

    $display("[TB] call and ret");
    applyStimulus(ICALL, SAOK, 64'h1F0, 64'h40, 4'h4, RNONE);
    runAccess(2, 64'h99, 1'b0, 1'b0);
    applyStimulus(IRET, SAOK, 64'h1F8, 64'h1F0, 4'h4, RNONE);
    runAccess(0, 64'h40, 1'b0, 1'b0);

    $display("[TB] irmovq, stray ack, then bubble and stall");
    applyStimulus(IIRMOVQ, SAOK, 64'h42, 64'h0, 4'h3, RNONE);
    @(posedge clk); #1;
    memory_bubble = 1'b1; dmem_ack = 1'b1; dmem_err = 1'b1; dmem_rdata = 64'hBAD;
    @(negedge clk);
    checkOutput("irmov_req", 64'(dmem_req), 64'd0);
    checkOutput("irmov_busy", 64'(mem_busy), 64'd0);
    checkOutput("irmov_icode", 64'(icode_out), 64'(IIRMOVQ));
    checkOutput("irmov_valE", vale_out, 64'h42);
    checkOutput("irmov_dstE", 64'(dste_out), 64'h3);
    @(posedge clk); #1;
    memory_bubble = 1'b0; dmem_ack = 1'b0; dmem_err = 1'b0;
    @(negedge clk);
    checkOutput("bubble_icode", 64'(icode_out), 64'(INOP));
    checkOutput("bubble_dstE", 64'(dste_out), 64'(RNONE));
    checkOutput("bubble_dstM", 64'(dstm_out), 64'(RNONE));
    checkOutput("bubble_valE", vale_out, 64'd0);
    checkOutput("stray_ack_stat", 64'(m_stat), 64'(SAOK));
    checkOutput("stray_ack_valM", valm_out, 64'd0);
    memory_stall = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("stall_hold", 64'(icode_out), 64'(INOP));
    memory_stall = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("stall_release", 64'(icode_out), 64'(IIRMOVQ));

    $display("[TB] rmmovq with non-AOK status");
    applyStimulus(IRMMOVQ, SINS, 64'h100, 64'h5, RNONE, RNONE);
    @(posedge clk); #1;
    applyStimulus(INOP, SAOK, 64'd0, 64'd0, RNONE, RNONE);
    @(negedge clk);
    checkOutput("sins_req", 64'(dmem_req), 64'd0);
    checkOutput("sins_stat", 64'(stat_out), 64'(SINS));
    checkOutput("sins_m_stat", 64'(m_stat), 64'(SINS));

    $display("[TB] rmmovq to misaligned address");
    applyStimulus(IRMMOVQ, SAOK, 64'h103, 64'h77, RNONE, RNONE);
`ifdef MEM_ALIGN_CHECK_EN
    @(posedge clk); #1;
    applyStimulus(INOP, SAOK, 64'd0, 64'd0, RNONE, RNONE);
    @(negedge clk);
    checkOutput("misalign_req", 64'(dmem_req), 64'd0);
    checkOutput("misalign_busy", 64'(mem_busy), 64'd0);
    checkOutput("misalign_m_stat", 64'(m_stat), 64'(SADR));
    checkOutput("misalign_stat", 64'(stat_out), 64'(SADR));
`else
    runAccess(0, 64'h0, 1'b0, 1'b0);
`endif

    $display("[TB] reset while waiting for ack");
    applyStimulus(IMRMOVQ, SAOK, 64'h300, 64'h0, RNONE, 4'h1);
    @(posedge clk); #1;
    applyStimulus(INOP, SAOK, 64'd0, 64'd0, RNONE, RNONE);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("wait_req", 64'(dmem_req), 64'd1);
    checkOutput("sb_pending_rst", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() != 0) checkOutput("wait_addr", dmem_addr, exp_q.pop_front().addr);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_req", 64'(dmem_req), 64'd0);
    checkOutput("midrst_icode", 64'(icode_out), 64'(INOP));
    checkOutput("midrst_stat", 64'(stat_out), 64'(SAOK));
    checkOutput("midrst_dstE", 64'(dste_out), 64'(RNONE));
    @(posedge clk); #1;
    rst_n = 1'b1; dmem_ack = 1'b1; dmem_err = 1'b1; dmem_rdata = 64'hF00D;
    @(negedge clk);
    checkOutput("late_ack_req", 64'(dmem_req), 64'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_err = 1'b0;
    @(negedge clk);
    checkOutput("late_ack_stat", 64'(m_stat), 64'(SAOK));
    checkOutput("late_ack_valM", valm_out, 64'd0);

    $display("[TB] random aligned reads");
    for (int i = 0; i < 4; i++) begin
      ra = {$urandom, $urandom} & ~64'h7;
      rd = {$urandom, $urandom};
      applyStimulus(IMRMOVQ, SAOK, ra, 64'h0, RNONE, 4'(i));
      runAccess(int'($urandom_range(0, 2)), rd, 1'b0, 1'b0);
    end

    checkOutput("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
